// File: rtl/debounce_filter.sv
// debounce_filter
//
// Turns a raw, bouncing mechanical switch level into a clean debounced level
// plus one-cycle press (0->1) and release (1->0) strobes. A new level must be
// held for DEBOUNCE_LIMIT consecutive cycles after the first differing sample
// before it is accepted; any reversal before then cancels the pending change.
//
// Parameters:
//   DEBOUNCE_LIMIT  cycles a new level must persist (>= 2). 250000 = 10 ms @ 25 MHz.
//
// Ports:
//   i_Clk      in   system clock, rising edge
//   i_Reset    in   asynchronous active-high reset
//   i_Switch   in   raw switch level (may bounce, may be asynchronous)
//   o_Switch   out  debounced level (registered)
//   o_Press    out  one-cycle pulse when o_Switch rises
//   o_Release  out  one-cycle pulse when o_Switch falls
//
// Compile-time option:
//   DEBOUNCE_SYNC_EN  when defined, i_Switch passes through a two-flop
//                     synchronizer first (adds 2 cycles to every latency).
//                     Leave undefined only for simulation or sources that are
//                     already synchronous to i_Clk.

module debounce_filter #(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Press,
  output logic o_Release
);

  localparam int CW = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CW-1:0] COUNT_MAX = CW'(DEBOUNCE_LIMIT - 1);

  // Bit 1 of the encoding is the debounced level, so o_Switch comes straight
  // off a state flop with no decode glitches.
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    COUNT_HIGH  = 2'b01,
    STABLE_HIGH = 2'b10,
    COUNT_LOW   = 2'b11
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   count_reg, count_next;
  logic            press_reg, press_next;
  logic            release_reg, release_next;
  logic            s;

  // ------------------------------------------------------------------
  // Input sampling
  // ------------------------------------------------------------------
`ifdef DEBOUNCE_SYNC_EN
  logic [1:0] sync_reg;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], i_Switch};
    end
  end

  assign s = sync_reg[1];
`else
  assign s = i_Switch;
`endif

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_reg   <= STABLE_LOW;
      count_reg   <= '0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      press_reg   <= press_next;
      release_reg <= release_next;
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  // The counter is cleared on every state change and held at zero in the
  // stable states, so it only ever advances while a change is pending and
  // never needs to wrap.
  always_comb begin
    state_next   = state_reg;
    count_next   = '0;
    press_next   = 1'b0;
    release_next = 1'b0;

    case (state_reg)
      STABLE_LOW: begin
        if (s) begin
          state_next = COUNT_HIGH;
        end
      end

      STABLE_HIGH: begin
        if (!s) begin
          state_next = COUNT_LOW;
        end
      end

      COUNT_HIGH: begin
        if (!s) begin
          // Bounce: drop back silently.
          state_next = STABLE_LOW;
        end else if (count_reg == COUNT_MAX) begin
          state_next = STABLE_HIGH;
          press_next = 1'b1;
        end else begin
          count_next = count_reg + CW'(1);
        end
      end

      COUNT_LOW: begin
        if (s) begin
          // Bounce: drop back silently.
          state_next = STABLE_HIGH;
        end else if (count_reg == COUNT_MAX) begin
          state_next   = STABLE_LOW;
          release_next = 1'b1;
        end else begin
          count_next = count_reg + CW'(1);
        end
      end

      default: begin
        state_next = STABLE_LOW;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  // Pulses are only raised on a commit, which always lands in a stable
  // state, so they can never repeat on the following cycle or coincide.
  always_comb begin
    o_Switch  = state_reg[1];
    o_Press   = press_reg;
    o_Release = release_reg;
  end

endmodule

// File: tb/tb_debounce_filter.sv
// Testbench for debounce_filter with DEBOUNCE_LIMIT = 8.
// Directed table of edge-by-edge vectors for clean press, bounce rejection
// and clean release; hand sequences for asynchronous reset and reset
// mid-count; then a randomized bouncing input checked against a run-length
// reference model.

module tb_debounce_filter;

  localparam int LIMIT = 8;
`ifdef DEBOUNCE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk;
  logic i_Reset;
  logic i_Switch;
  logic o_Switch;
  logic o_Press;
  logic o_Release;

  int tests_run;
  int tests_failed;

  debounce_filter #(
    .DEBOUNCE_LIMIT(LIMIT)
  ) dut (
    .i_Clk    (clk),
    .i_Reset  (i_Reset),
    .i_Switch (i_Switch),
    .o_Switch (o_Switch),
    .o_Press  (o_Press),
    .o_Release(o_Release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Accepted level flips once the sampled input has disagreed with it on
  // LIMIT+1 consecutive edges; any agreeing edge resets the run.
  bit m_level;
  int m_run;
  bit m_press;
  bit m_rel;
  bit m_dly [2];

  function automatic void model_reset();
    m_level  = 1'b0;
    m_run    = 0;
    m_press  = 1'b0;
    m_rel    = 1'b0;
    m_dly[0] = 1'b0;
    m_dly[1] = 1'b0;
  endfunction

  function automatic void model_step(input bit sw);
    bit s;
    if (LAT == 0) begin
      s = sw;
    end else begin
      s = m_dly[1];
      m_dly[1] = m_dly[0];
      m_dly[0] = sw;
    end
    m_press = 1'b0;
    m_rel   = 1'b0;
    if (s != m_level) begin
      m_run++;
      if (m_run == LIMIT + 1) begin
        m_level = s;
        m_run   = 0;
        if (s) m_press = 1'b1;
        else   m_rel   = 1'b1;
      end
    end else begin
      m_run = 0;
    end
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [2:0] want);
    logic [2:0] got;
    got = {o_Switch, o_Press, o_Release};
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got sw/press/rel=%b required %b at t=%0t", name, got, want, $time);
    end else begin
      $display("ok   %s: sw/press/rel=%b", name, got);
    end
  endtask

  // One edge with input sw, checked against the model.
  task automatic cycle(input bit sw, input string name);
    i_Switch = sw;
    @(posedge clk);
    #1;
    model_step(sw);
    check(name, {m_level, m_press, m_rel});
  endtask

  // One edge with input sw, checked against an explicit expectation.
  task automatic cycle_exp(input bit sw, input logic [2:0] want, input string name);
    i_Switch = sw;
    @(posedge clk);
    #1;
    model_step(sw);
    check(name, want);
  endtask

  // Reset asserted between edges; outputs must clear with no clock edge.
  task automatic do_reset(input string name);
    i_Reset = 1'b1;
    #2;
    check(name, 3'b000);
    @(posedge clk);
    @(posedge clk);
    #1;
    i_Reset = 1'b0;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         sw;
    logic [2:0] want;   // {o_Switch, o_Press, o_Release}
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int n, input bit sw, input logic [2:0] want);
    vec_t v;
    v.sw   = sw;
    v.want = want;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    i_Reset      = 1'b0;
    i_Switch     = 1'b0;
    model_reset();

    // Edge numbers in comments count from the first edge after reset release.
    add(9,  1'b0, 3'b000);  // edges 1-9   idle low
    add(8,  1'b1, 3'b000);  // edges 10-17 pending press
    add(1,  1'b1, 3'b110);  // edge 18     commit + press
    add(21, 1'b1, 3'b100);  // edges 19-39 held high
    add(8,  1'b0, 3'b100);  // edges 40-47 pending release
    add(1,  1'b0, 3'b001);  // edge 48     commit + release
    add(4,  1'b0, 3'b000);  // edges 49-52
    add(5,  1'b1, 3'b000);  // edges 53-57 high for 5
    add(1,  1'b0, 3'b000);  // edge 58     bounce low
    add(8,  1'b1, 3'b000);  // edges 59-66 recount from final rise
    add(1,  1'b1, 3'b110);  // edge 67     single press
    add(3,  1'b1, 3'b100);  // edges 68-70

    @(posedge clk);
    #1;
    do_reset("reset_initial");

    // With the synchronizer the whole expected trace slides LAT edges later.
    for (int i = 0; i < vecs.size(); i++) begin
      logic [2:0] want;
      want = (i >= LAT) ? vecs[i - LAT].want : 3'b000;
      cycle_exp(vecs[i].sw, want, $sformatf("table_edge%0d", i + 1));
    end

    // o_Switch is high here; asynchronous reset must clear it immediately.
    do_reset("reset_async_from_high");
    cycle_exp(1'b0, 3'b000, "after_reset_low");

    // Reset while a press is mid-count (counter at 5).
    for (int i = 0; i < 6 + LAT; i++) cycle(1'b1, "midcount_pre");
    i_Reset = 1'b1;
    #2;
    check("midcount_reset_async", 3'b000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("midcount_in_reset", 3'b000);
    end
    i_Reset = 1'b0;
    model_reset();
    for (int i = 0; i < LIMIT + LAT; i++) cycle_exp(1'b1, 3'b000, "midcount_recount");
    cycle_exp(1'b1, 3'b110, "midcount_press");
    cycle_exp(1'b1, 3'b100, "midcount_press_end");

    // Randomized bouncing input: alternate levels with random hold lengths
    // around the limit so both bounces and commits occur.
    begin
      bit cur;
      int hold;
      cur  = i_Switch;
      hold = 0;
      for (int i = 0; i < 3000; i++) begin
        if (i == 1500) do_reset("random_reset");
        if (hold == 0) begin
          cur  = ~cur;
          hold = $urandom_range(1, 14);
        end
        hold--;
        cycle(cur, "random");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
